fp_mul_byte_io: RTL and testbench
=================================

Name: fp_mul_byte_io

Overview:
- Byte-serial operand loader and result unloader wrapped around the team's combinational FP32 multiplier, for pin-limited chip top-levels.
- Collects operand A and operand B as 8 bytes over a valid/ready input port and drives them onto the multiplier inputs.
- Captures the product and overflow flag after a programmable settle delay.
- Returns 4 result bytes plus 1 status byte over a valid/ready output port.
- Sits directly upstream of the multiplier (drives A/B) and directly downstream of it (consumes O/OF); the multiplier is instantiated beside it at the chip top.

Parameters:
- CAPTURE_DLY, 1: clock edges spent in WAIT before sampling mul_o/mul_of. Legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid operand byte.
- in_ready  out  1  block accepts a byte this cycle.
- in_data  in  8  operand byte.
- out_valid  out  1  out_data holds a valid result/status byte.
- out_ready  in  1  sink accepts out_data this cycle.
- out_data  out  8  result/status byte.
- mul_a  out  32  operand A to multiplier (register output).
- mul_b  out  32  operand B to multiplier (register output).
- mul_o  in  32  multiplier product.
- mul_of  in  1  multiplier exponent-overflow flag.
- busy  out  1  high unless in LOAD with byte index 0.

Behaviour:
- Reset (synchronous, active-high): state=LOAD; in_idx=0; out_idx=0; dly_cnt=0; mul_a=0; mul_b=0; res_reg=0; stat_reg=0. Resulting outputs: out_valid=0, in_ready=1, busy=0, out_data=0.
- Reset mid-operation discards any partial operands or pending output bytes. No partial byte is ever emitted after reset.
- States: LOAD, WAIT, SEND. All control outputs decode combinationally from registered state.
- LOAD:
  - in_ready=1, out_valid=0.
  - A byte is accepted on an edge where in_valid&in_ready.
  - Byte order: in_idx 0..3 write mul_a[8*i+7:8*i] (little-endian, LSB first); in_idx 4..7 write mul_b[8*(i-4)+7:8*(i-4)].
  - in_idx increments per accepted byte. The 8th byte sets in_idx=0, dly_cnt=0, state=WAIT.
  - in_valid low is a gap and leaves all state unchanged.
- mul_a/mul_b change only on accepted bytes and hold otherwise, including during WAIT and SEND.
- WAIT:
  - in_ready=0, out_valid=0.
  - Each edge: if dly_cnt==CAPTURE_DLY-1, then res_reg<=mul_o, stat_reg<=status(mul_o,mul_of), out_idx<=0, state<=SEND; else dly_cnt++.
  - Capture latency: CAPTURE_DLY edges after entering WAIT.
- Status byte (computed from the captured value):
  - bit0 = mul_of.
  - bit1 = zero: mul_o[30:0]==0.
  - bit2 = inf: mul_o[30:23]==8'hFF && mul_o[22:0]==0.
  - bit3 = nan: mul_o[30:23]==8'hFF && mul_o[22:0]!=0.
  - bits7:4 = 0.
- SEND:
  - out_valid=1, in_ready=0.
  - out_data = res_reg byte out_idx (LSB first) for out_idx 0..3; stat_reg for out_idx 4.
  - On an edge where out_valid&out_ready: out_idx++. After the 5th byte, state=LOAD and out_idx=0.
  - out_data and out_valid stay stable while out_ready=0; no timeout.
- Minimum transaction: 8 input cycles + CAPTURE_DLY + 5 output cycles.
- The next operand byte is accepted on the cycle after the final status-byte handshake.
- No input/output overlap: in_ready and out_valid are never both 1.

Test Plan:
- Nominal product: multiplier connected; bytes 00 00 C0 3F 00 00 00 40 (A=1.5, B=2.0) → output bytes 00 00 40 40 00 (O=0x40400000, status 0x00).
- Zero operand: A=0x00000000, B=0x40000000 → bytes 00 00 00 00 02.
- Inf×zero: A=0x7F800000, B=0x00000000 → O=0x7FFFFFFF, bytes FF FF FF 7F 08.
- Overflow: A=B=0x7F000000 → O=0x3E800000, bytes 00 00 80 3E 01. Repeat with CAPTURE_DLY=4 and confirm the first out_valid rises exactly 4 cycles after the 8th input handshake.
- Handshake stress:
  - Random in_valid gaps → operands unaffected.
  - Hold out_ready=0 for 3 cycles on output byte 2 → out_data held at 0x40 and out_valid held high.
  - in_ready stays 0 throughout SEND.
- Reset mid-load: assert rst after 5 bytes → in_idx=0, mul_a=mul_b=0, busy=0. The next 8 bytes form a fresh operand pair with the correct product.

Source files
------------

// File: rtl/fp_mul_byte_io.sv
// Byte-serial front/back end for the combinational FP32 multiplier: loads A/B as
// 8 little-endian bytes, captures the product after CAPTURE_DLY edges, returns 5 bytes.
module fp_mul_byte_io #(
  parameter int unsigned CAPTURE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_o,
  input  logic        mul_of,
  output logic        busy
);

  typedef enum logic [1:0] {LOAD, WAIT, SEND} state_t;

  localparam logic [3:0] DLY_LAST = 4'(CAPTURE_DLY - 1);

  state_t      state, state_nx;
  logic [2:0]  in_idx;
  logic [2:0]  out_idx;
  logic [3:0]  dly_cnt;
  logic [31:0] res_reg;
  logic [7:0]  stat_reg;
  logic        in_fire, out_fire;
  logic        o_exp_max, o_man_zero;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign o_exp_max  = (mul_o[30:23] == 8'hFF);
  assign o_man_zero = (mul_o[22:0] == 23'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = (in_idx != 3'd0);
        if (in_fire && in_idx == 3'd7) state_nx = WAIT;
      end
      WAIT: begin
        if (dly_cnt == DLY_LAST) state_nx = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = (out_idx == 3'd4) ? stat_reg : res_reg[{out_idx[1:0], 3'b000} +: 8];
        if (out_fire && out_idx == 3'd4) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx   <= '0;
      out_idx  <= '0;
      dly_cnt  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      res_reg  <= '0;
      stat_reg <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            // in_idx[2] selects the operand, in_idx[1:0] the byte lane within it
            if (in_idx[2]) mul_b[{in_idx[1:0], 3'b000} +: 8] <= in_data;
            else           mul_a[{in_idx[1:0], 3'b000} +: 8] <= in_data;
            in_idx <= in_idx + 3'd1;
            if (in_idx == 3'd7) dly_cnt <= '0;
          end
        end
        WAIT: begin
          if (dly_cnt == DLY_LAST) begin
            res_reg  <= mul_o;
            stat_reg <= {4'b0000,
                         o_exp_max & ~o_man_zero,
                         o_exp_max & o_man_zero,
                         (mul_o[30:0] == 31'd0),
                         mul_of};
            out_idx  <= '0;
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end
        SEND: begin
          if (out_fire) out_idx <= (out_idx == 3'd4) ? 3'd0 : out_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_byte_io.sv
// Bench for fp_mul_byte_io: two instances (CAPTURE_DLY 1 and 4), each fed by a
// behavioural multiplier stand-in; expected bytes come from a field-level model.
module tb_fp_mul_byte_io;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  in_data;
  logic        out_valid [2];
  logic        out_ready;
  logic [7:0]  out_data [2];
  logic [31:0] mul_a [2];
  logic [31:0] mul_b [2];
  logic [31:0] mul_o [2];
  logic        mul_of [2];
  logic        busy [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in for the team multiplier: known test-plan pairs, otherwise a hash whose
  // class (normal / inf / nan / zero) is steered by the low bits of A.
  function automatic logic [32:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40000000: return {1'b0, 32'h40400000};
      64'h00000000_40000000: return {1'b0, 32'h00000000};
      64'h7F800000_00000000: return {1'b0, 32'h7FFFFFFF};
      64'h7F000000_7F000000: return {1'b1, 32'h3E800000};
      default: begin
        case (a[1:0])
          2'd0:    return {^(a ^ b), (a * b) ^ (b >> 5)};
          2'd1:    return {a[2], b[31], 8'hFF, 23'd0};
          2'd2:    return {a[2], b[31], 8'hFF, b[22:0] | 23'd1};
          default: return {a[2], b[31], 31'd0};
        endcase
      end
    endcase
  endfunction

  function automatic logic [7:0] status_of(input logic [31:0] o, input logic of);
    logic [7:0] e;
    logic [22:0] m;
    e = o[30:23];
    m = o[22:0];
    return {4'd0, (e == 8'd255) && (m != 0), (e == 8'd255) && (m == 0),
            (o & 32'h7FFF_FFFF) == 0, of};
  endfunction

  assign {mul_of[0], mul_o[0]} = stub_mul(mul_a[0], mul_b[0]);
  assign {mul_of[1], mul_o[1]} = stub_mul(mul_a[1], mul_b[1]);

  fp_mul_byte_io #(.CAPTURE_DLY(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_o(mul_o[0]), .mul_of(mul_of[0]), .busy(busy[0]));

  fp_mul_byte_io #(.CAPTURE_DLY(4)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_o(mul_o[1]), .mul_of(mul_of[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("excl", {in_ready[0] & out_valid[0], in_ready[1] & out_valid[1]}, 40'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input int gaps);
    int n;
    in_valid[k] = 1'b0;
    repeat (gaps) step();
    in_valid[k] = 1'b1;
    in_data = b;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("in_timeout", 1'b1, 1'b0);
    step();
    in_valid[k] = 1'b0;
    in_data = $urandom();
  endtask

  task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                         input int gaps, input int stall, input int dly);
    logic [63:0] ops;
    logic [32:0] prod;
    logic [39:0] exp_bytes;
    int lat;
    ops = {b, a};
    for (int i = 0; i < 8; i++) begin
      push_byte(k, ops[8*i +: 8], $urandom_range(0, gaps));
      if (i == 0) check("busy_load", busy[k], 1'b1);
    end
    check("mul_a", mul_a[k], a);
    check("mul_b", mul_b[k], b);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      check("wait_rdy", in_ready[k], 1'b0);
      step();
      lat++;
    end
    check("latency", lat, dly);
    prod = stub_mul(a, b);
    exp_bytes = {status_of(prod[31:0], prod[32]), prod[31:0]};
    for (int i = 0; i < 5; i++) begin
      if (i == stall) begin
        out_ready = 1'b0;
        repeat (3) begin
          step();
          check("stall_valid", out_valid[k], 1'b1);
          check("stall_data", out_data[k], exp_bytes[8*i +: 8]);
        end
      end
      out_ready = 1'b1;
      check("out_valid", out_valid[k], 1'b1);
      check("out_data", out_data[k], exp_bytes[8*i +: 8]);
      check("send_rdy", in_ready[k], 1'b0);
      step();
      out_ready = 1'b0;
    end
    check("end_valid", out_valid[k], 1'b0);
    check("end_rdy", in_ready[k], 1'b1);
    check("end_busy", busy[k], 1'b0);
    check("hold_a", mul_a[k], a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", out_valid[k], 1'b0);
      check("rst_rdy", in_ready[k], 1'b1);
      check("rst_busy", busy[k], 1'b0);
      check("rst_data", out_data[k], 8'h00);
      check("rst_ab", {mul_a[k], mul_b[k]}, 40'd0);
    end
    rst = 1'b0;

    run_txn(0, 32'h3FC00000, 32'h40000000, 0, 2, 1);
    run_txn(0, 32'h00000000, 32'h40000000, 0, 5, 1);
    run_txn(0, 32'h7F800000, 32'h00000000, 2, 5, 1);
    run_txn(0, 32'h7F000000, 32'h7F000000, 0, 5, 1);
    run_txn(1, 32'h7F000000, 32'h7F000000, 0, 5, 4);
    run_txn(1, 32'h3FC00000, 32'h40000000, 3, 2, 4);

    // Reset after 5 operand bytes must discard the partial operands.
    for (int i = 0; i < 5; i++) push_byte(0, 8'hA0 + 8'(i), $urandom_range(0, 2));
    check("part_busy", busy[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_ab", {mul_a[0], mul_b[0]}, 40'd0);
    check("mid_busy", busy[0], 1'b0);
    check("mid_rdy", in_ready[0], 1'b1);
    check("mid_valid", out_valid[0], 1'b0);
    run_txn(0, 32'h3FC00000, 32'h40000000, 1, 5, 1);

    for (int t = 0; t < 24; t++) begin
      ra = $urandom();
      rb = $urandom();
      run_txn(t % 2, ra, rb, 3, $urandom_range(0, 6), (t % 2 == 0) ? 1 : 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
